// File: rtl/adc_rdbus_ctrl_if.sv
// Host-bus strobes, capture-buffer read port and status outputs of the ADC read-bus sequencer.
interface adc_rdbus_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ROW_W  = 8
);
  logic              cs_res;
  logic              cs_laddr;
  logic              cs_haddr;
  logic              cs_row;
  logic              cs_read;
  logic [7:0]        data_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_rvalid;
  logic [7:0]        bus_dout;
  logic [ROW_W-1:0]  row_sel;
  logic              row_load;
  logic              soft_rst;
  logic              busy;
  logic              ovr;

  modport slave (
    input  cs_res, cs_laddr, cs_haddr, cs_row, cs_read, data_in, mem_rdata, mem_rvalid,
    output mem_addr, mem_rd, bus_dout, row_sel, row_load, soft_rst, busy, ovr
  );

  modport master (
    output cs_res, cs_laddr, cs_haddr, cs_row, cs_read, data_in, mem_rdata, mem_rvalid,
    input  mem_addr, mem_rd, bus_dout, row_sel, row_load, soft_rst, busy, ovr
  );
endinterface

// File: rtl/adc_rdbus_ctrl.sv
// Resynchronises host chip-select strobes, tracks the buffer read pointer / row select
// and prefetches the next buffer byte so host reads see auto-incrementing data.
module adc_rdbus_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ROW_W  = 8,
  parameter int unsigned MEM_TO = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  adc_rdbus_ctrl_if.slave  bus
);

  localparam int unsigned NCS      = 5;
  localparam int unsigned TMR_W    = $clog2(MEM_TO + 1);
  localparam int unsigned EV_RES   = 0;
  localparam int unsigned EV_LADDR = 1;
  localparam int unsigned EV_HADDR = 2;
  localparam int unsigned EV_ROW   = 3;
  localparam int unsigned EV_READ  = 4;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [NCS-1:0]    w_cs_pin;
  logic [NCS-1:0]    r_cs_s1, r_cs_s2, r_cs_s3;
  logic [NCS-1:0]    w_ev;
  logic [7:0]        r_data;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt, r_mem_addr;
  logic              w_rd_ok, w_row_ok, w_start;
  state_t            r_state;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_mem_rd, r_pend, r_discard, r_busy, r_ovr;
  logic              r_soft_rst, r_row_pend, r_row_load;
  logic [7:0]        r_bus_dout;
  logic [ROW_W-1:0]  r_row_sel;

  assign w_cs_pin = {bus.cs_read, bus.cs_row, bus.cs_haddr, bus.cs_laddr, bus.cs_res};
  // Command event = synchronised strobe release (low-to-high).
  assign w_ev     = r_cs_s2 & ~r_cs_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s1 <= '1;
      r_cs_s2 <= '1;
      r_cs_s3 <= '1;
    end else begin
      r_cs_s1 <= w_cs_pin;
      r_cs_s2 <= r_cs_s1;
      r_cs_s3 <= r_cs_s2;
    end
  end

  // Capture host data while any synchronised write strobe is still low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (!(&r_cs_s2[EV_ROW:EV_LADDR])) begin
      r_data <= bus.data_in;
    end
  end

  // Event arbitration and next pointer value.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_rd_ok   = 1'b0;
    w_row_ok  = 1'b0;
    w_start   = 1'b0;
    if (w_ev[EV_RES]) begin
      w_ptr_nxt = '0;
      w_start   = 1'b1;
    end else begin
      if (w_ev[EV_LADDR]) w_ptr_nxt[7:0] = r_data;
      if (w_ev[EV_HADDR]) w_ptr_nxt[ADDR_W-1:8] = r_data[ADDR_W-9:0];
      w_row_ok = w_ev[EV_ROW];
      w_rd_ok  = w_ev[EV_READ] & ~w_ev[EV_LADDR] & ~w_ev[EV_HADDR];
      if (w_rd_ok) w_ptr_nxt = r_ptr + ADDR_W'(1);
      w_start  = w_ev[EV_LADDR] | w_ev[EV_HADDR] | w_rd_ok;
    end
  end

  // A new command always passes through IDLE so an aborted fetch is marked discarded first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_tmr      <= '0;
      r_pend     <= 1'b0;
      r_discard  <= 1'b0;
      r_busy     <= 1'b0;
      r_ovr      <= 1'b0;
      r_bus_dout <= '0;
      r_row_sel  <= '0;
      r_row_pend <= 1'b0;
      r_row_load <= 1'b0;
      r_soft_rst <= 1'b0;
    end else begin
      r_mem_rd   <= 1'b0;
      r_ptr      <= w_ptr_nxt;
      r_soft_rst <= w_ev[EV_RES];
      r_row_pend <= w_row_ok;
      r_row_load <= r_row_pend;
      if (w_row_ok) r_row_sel <= r_data[ROW_W-1:0];
      if (w_ev[EV_RES]) r_row_sel <= '0;

      if (w_start) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_pend  <= 1'b1;
        if (r_state == S_WAIT) r_discard <= 1'b1;
        if (w_rd_ok && r_busy) r_ovr <= 1'b1;
        if (w_ev[EV_RES]) begin
          r_ovr      <= 1'b0;
          r_bus_dout <= '0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_pend) begin
              r_mem_addr <= r_ptr;
              r_mem_rd   <= 1'b1;
              r_discard  <= 1'b0;
              r_pend     <= 1'b0;
              r_busy     <= 1'b1;
              r_tmr      <= '0;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.mem_rvalid && !r_discard) begin
              r_bus_dout <= bus.mem_rdata;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else if (r_tmr == TMR_W'(MEM_TO - 1)) begin
              r_ovr   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.bus_dout = r_bus_dout;
  assign bus.row_sel  = r_row_sel;
  assign bus.row_load = r_row_load;
  assign bus.soft_rst = r_soft_rst;
  assign bus.busy     = r_busy;
  assign bus.ovr      = r_ovr;

endmodule

// File: doc/adc_rdbus_ctrl.md
Name: adc_rdbus_ctrl

Overview:
- Host-bus-side sequencer for the ADC capture buffer.
- Consumes the active-low chip-select strobes produced by the bus address decoder: reset-all (addr 20 write), low address (21), high address (22), load row (23) and read data (20 read).
- Resynchronises the strobes into clk and maintains the buffer read pointer and the row select.
- Prefetches buffer bytes so the host sees read data with auto-increment addressing.

Parameters:
ADDR_W, 16, buffer address width (9..16); low byte from the laddr write, bits [ADDR_W-1:8] from the haddr write.
ROW_W, 8, row select width (1..8), taken from data_in[ROW_W-1:0].
MEM_TO, 15, maximum clk cycles to wait for mem_rvalid before abandoning a fetch.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cs_res  in  1  active-low async strobe, reset-all command
cs_laddr  in  1  active-low async strobe, write low address byte
cs_haddr  in  1  active-low async strobe, write high address byte
cs_row  in  1  active-low async strobe, load row select
cs_read  in  1  active-low async strobe, host data read
data_in  in  8  host write data, async, valid while a write strobe is low
mem_addr  out  ADDR_W  buffer read address
mem_rd  out  1  one-cycle buffer read request
mem_rdata  in  8  buffer read data
mem_rvalid  in  1  mem_rdata valid, one cycle
bus_dout  out  8  byte presented to host during cs_read
row_sel  out  ROW_W  current row select
row_load  out  1  one-cycle pulse after row_sel updates
soft_rst  out  1  one-cycle pulse on reset-all command
busy  out  1  fetch in progress
ovr  out  1  sticky: read completed while busy or fetch timed out

Behaviour:
- Reset (rst_n low, async): ptr=0, mem_addr=0, mem_rd=0, bus_dout=8'h00, row_sel=0, row_load=0, soft_rst=0, busy=0, ovr=0, FSM=IDLE, all synchroniser flops=1 (inactive).
- Each strobe passes through a 2-FF synchroniser plus a third edge flop.
- A command event is the synchronised rising edge (strobe release). Latency is 3 clk from the strobe pin going high to the event.
- data_in is registered every clk while any synchronised write strobe is low. The event uses that last registered value.
- Simultaneous events priority: res > laddr > haddr > row > read.
- A lower-priority event in the same cycle as res is dropped. laddr, haddr and row in the same cycle all apply. A read in the same cycle as an address write is dropped.
- res event: ptr=0, row_sel=0, bus_dout=0, ovr=0, soft_rst pulses 1 cycle. Any in-flight fetch is aborted: FSM→IDLE, a later mem_rvalid for it is discarded via a discard flag, cleared on next mem_rd. Then a prefetch of address 0 starts.
- laddr event: ptr[7:0]=data; start prefetch.
- haddr event: ptr[ADDR_W-1:8]=data[ADDR_W-9:0]; start prefetch.
- row event: row_sel=data[ROW_W-1:0]; row_load pulses the following cycle. No fetch.
- read event (host has sampled bus_dout):
  - ptr increments modulo 2^ADDR_W (all-ones wraps to 0); start prefetch.
  - If busy at the event, set ovr, still increment, and restart the prefetch at the new ptr (the old fetch is discarded).
- FSM:
  - IDLE: on prefetch start, mem_addr=ptr, mem_rd=1 for one cycle → WAIT.
  - WAIT: busy=1. mem_rvalid (not discarded) → bus_dout=mem_rdata → IDLE. After MEM_TO cycles without it → ovr=1, bus_dout unchanged → IDLE.
- bus_dout changes only on an accepted mem_rvalid or a res event. It is stable while cs_read is low, provided the host leaves at least 3+fetch-latency clk between reads.
- rst_n asserted mid-fetch: immediate return to reset values. No mem_rd is issued until a command arrives.

Test Plan:
- Reset then res event: soft_rst pulses 1 cycle, mem_rd to addr 0x0000; mem_rdata=0xA5 with rvalid 2 cycles later → bus_dout=0xA5, busy 1→0.
- Write laddr 0x34, haddr 0x12 → ptr 0x1234, mem_rd at 0x1234. Three cs_read pulses → fetches at 0x1235, 0x1236, 0x1237 with bus_dout following memory.
- ptr=0xFFFF plus one read → mem_addr 0x0000 (wrap), no ovr.
- Write row 0x07 → row_sel=0x07, row_load pulses once exactly 1 cycle after the update, no mem_rd.
- Second cs_read released while WAIT (rvalid withheld) → ovr=1, stale rvalid ignored, new fetch at ptr+2. With no rvalid for MEM_TO cycles → ovr=1, FSM in IDLE.
- cs_res and cs_row released in the same cycle → row_sel=0, no row_load. rst_n low during WAIT → all outputs at reset values, and a late mem_rvalid leaves bus_dout=0.
